// File: rtl/text_buf_arbiter.sv
// Arbitrates the text buffer's single memory port between the renderer (absolute priority)
// and two round-robin write requesters, with sticky starvation detection on the writers.
module text_buf_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 7,
    parameter int STARVE_MAX = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_starve
);

    localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic             wr0_elig, wr1_elig;
    logic             gnt_rd, gnt_wr0, gnt_wr1;
    logic             rr_favor_wr1;
    logic [CNT_W-1:0] wait0, wait1, wait0_nxt, wait1_nxt;

    // A requester still sees req high during its ack cycle; masking it prevents a double write.
    assign wr0_elig = wr0_req & ~wr0_ack;
    assign wr1_elig = wr1_req & ~wr1_ack;

    always_comb begin
        gnt_rd  = rd_req;
        gnt_wr0 = 1'b0;
        gnt_wr1 = 1'b0;
        if (!rd_req) begin
            if (wr0_elig && wr1_elig) begin
                gnt_wr0 = ~rr_favor_wr1;
                gnt_wr1 = rr_favor_wr1;
            end else begin
                gnt_wr0 = wr0_elig;
                gnt_wr1 = wr1_elig;
            end
        end
    end

    always_comb begin
        wait0_nxt = wait0;
        if (gnt_wr0 || !wr0_req)
            wait0_nxt = '0;
        else if (wr0_elig && wait0 != CNT_MAX)
            wait0_nxt = wait0 + CNT_W'(1);

        wait1_nxt = wait1;
        if (gnt_wr1 || !wr1_req)
            wait1_nxt = '0;
        else if (wr1_elig && wait1 != CNT_MAX)
            wait1_nxt = wait1 + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rd_valid     <= 1'b0;
            wr0_ack      <= 1'b0;
            wr1_ack      <= 1'b0;
            rr_favor_wr1 <= 1'b0;
            wait0        <= '0;
            wait1        <= '0;
            err_starve   <= 1'b0;
        end else begin
            mem_en  <= gnt_rd | gnt_wr0 | gnt_wr1;
            mem_we  <= gnt_wr0 | gnt_wr1;
            wr0_ack <= gnt_wr0;
            wr1_ack <= gnt_wr1;
            if (gnt_rd) begin
                mem_addr <= rd_addr;
            end else if (gnt_wr0) begin
                mem_addr  <= wr0_addr;
                mem_wdata <= wr0_data;
            end else if (gnt_wr1) begin
                mem_addr  <= wr1_addr;
                mem_wdata <= wr1_data;
            end

            if (gnt_wr0)
                rr_favor_wr1 <= 1'b1;
            else if (gnt_wr1)
                rr_favor_wr1 <= 1'b0;

            // Memory returns data the cycle after a read access is presented.
            rd_valid <= mem_en & ~mem_we;

            wait0 <= wait0_nxt;
            wait1 <= wait1_nxt;
            if (wait0_nxt == CNT_MAX || wait1_nxt == CNT_MAX)
                err_starve <= 1'b1;
        end
    end

    assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: doc/text_buf_arbiter.md
TEXT_BUF_ARBITER -- requirements
Module: text_buf_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, meaning character-cell address width (80x30 = 2400 cells).
REQ-002 The module SHALL have parameter DATA_W, default 7, meaning ASCII code width.
REQ-003 The module SHALL have parameter STARVE_MAX, default 1023, meaning the maximum number of cycles a write may wait before the starvation flag sets.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: rd_req  input  1  text-renderer read request, one cell per cycle.
REQ-007 Port: rd_addr  input  ADDR_W  renderer cell address.
REQ-008 Port: rd_data  output  DATA_W  read data returned to the renderer.
REQ-009 Port: rd_valid  output  1  rd_data valid strobe.
REQ-010 Ports: wr0_req, wr1_req  input  1 each  write requests (wr0 = CPU debug writer, wr1 = switch-entry writer).
REQ-011 Ports: wr0_addr, wr1_addr  input  ADDR_W each; wr0_data, wr1_data  input  DATA_W each.
REQ-012 Ports: wr0_ack, wr1_ack  output  1 each  one-cycle write-done pulses.
REQ-013 Ports: mem_en  output  1; mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  registered single-port buffer controls.
REQ-014 Port: mem_rdata  input  DATA_W  buffer read data, valid one cycle after mem_en with mem_we low.
REQ-015 Port: err_starve  output  1  sticky starvation flag.

Function
REQ-016 The block SHALL arbitrate once per cycle (cycle N) and drive the winner on the registered mem_* outputs in cycle N+1.
REQ-017 A read SHALL win whenever rd_req=1, regardless of pending writes (absolute priority).
REQ-018 A read won in cycle N SHALL drive mem_en=1, mem_we=0, mem_addr=rd_addr(N) in N+1, and rd_valid=1 with rd_data=mem_rdata in N+2; total read latency SHALL be 2 cycles.
REQ-019 Back-to-back reads SHALL be fully pipelined, one per cycle, with no bubbles.
REQ-020 When rd_req=0 and exactly one write request is eligible, that request SHALL win.
REQ-021 When rd_req=0 and both write requests are eligible, the requester not granted most recently SHALL win (round-robin); the pointer SHALL favour wr0 after reset.
REQ-022 A write won in cycle N SHALL drive mem_en=1, mem_we=1, and that requester's addr/data in N+1, and SHALL pulse the matching wrX_ack in N+1 for exactly one cycle.
REQ-023 Requesters SHALL hold req, addr, and data stable until ack, and SHALL deassert req in the cycle after ack.
REQ-024 The arbiter SHALL treat wrX_req as ineligible in any cycle in which wrX_ack=1, so a single request is never written twice.
REQ-025 In cycles with no winner, mem_en, mem_we, and both acks SHALL be 0; mem_addr and mem_wdata SHALL hold their previous values.
REQ-026 Each write requester SHALL have a wait counter that increments by one each cycle its request is eligible but loses, clears on grant or on req=0, and saturates at STARVE_MAX.
REQ-027 err_starve SHALL set in the cycle either wait counter reaches STARVE_MAX and SHALL remain 1 until reset; arbitration is unaffected.
REQ-028 A write request arriving in the same cycle as rd_req SHALL be deferred, not lost; it stays pending while req is held.

Reset
REQ-029 While reset=1 at a rising edge, the following SHALL become 0: mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wr0_ack, wr1_ack, err_starve, both wait counters; the round-robin pointer SHALL favour wr0.
REQ-030 Reset asserted with a read or write in flight SHALL abort it: no rd_valid and no ack appear afterwards for that access.
REQ-031 In the first cycle after reset deasserts, arbitration SHALL proceed normally from the inputs of that cycle.

Verification
REQ-032 Scenario: rd_req=1 for 4 cycles with addresses 0,1,2,3, memory preloaded with 0x41..0x44 -> rd_valid high for 4 consecutive cycles starting 2 cycles later, rd_data = 0x41, 0x42, 0x43, 0x44.
REQ-033 Scenario: wr0_req (addr 5, data 0x5A) and wr1_req (addr 6, data 0x30) asserted together, rd_req=0 -> wr0 written first with wr0_ack, wr1 written next cycle with wr1_ack; exactly one mem_we pulse per request.
REQ-034 Scenario: wr1_req held while rd_req=1 for 10 cycles -> no mem_we during the reads, then wr1 is written and wr1_ack pulses within 2 cycles of rd_req falling.
REQ-035 Scenario: STARVE_MAX=8, wr0_req held under continuous rd_req -> err_starve rises after 8 losing cycles and stays 1 after wr0 completes, until reset.
REQ-036 Scenario: reset asserted the cycle after a write grant -> wr0_ack never pulses, all outputs 0; wr0 still requesting after reset -> written normally.
